// File: rtl/slc3_mem_pkg.sv
// slc3_mem_pkg: shared state encoding and helpers for the SLC-3 RAM front end
package slc3_mem_pkg;
  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) idx = 3'(i);
    return idx;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, searching from ptr+1 upward with wraparound
module rr_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  int c;
  logic [2:0] idx8;
  // Walk the search order backwards so the closest requester after ptr wins last
  always_comb begin
    gnt = '0;
    c = 0;
    for (int i = N; i >= 1; i--) begin
      c = (int'(ptr) + i >= N) ? int'(ptr) + i - N : int'(ptr) + i;
      if (req[c]) begin
        gnt = '0;
        gnt[c] = 1'b1;
      end
    end
  end
  assign idx8 = onehot_to_idx(8'(gnt));
  assign idx = idx8[IW-1:0];
endmodule

// File: rtl/slc3_mem_arbiter.sv
// slc3_mem_arbiter: copies the init ROM into RAM, then round-robins NUM_CH requesters onto the RAM port
module slc3_mem_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 10,
  parameter int NUM_CH        = 2,
  parameter int INIT_WORDS    = 1024,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     init_req,
  output logic                     init_done,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_q,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_data,
  output logic                     ram_wren,
  output logic                     ram_rden,
  input  logic [DATA_W-1:0]        ram_q
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST = CW'(INIT_WORDS - 1);
  state_t state, state_nxt;
  logic [CW-1:0] iss_cnt, wr_cnt;
  logic [IW-1:0] ptr, c;
  logic [ADDR_W-1:0] addr_q;
  logic [NUM_CH-1:0] arb_req;
  logic any, issue, wr_act, clr;
  assign arb_req = (state == RUN) ? req : '0;
  rr_arbiter #(.N(NUM_CH), .IW(IW)) u_arb (
    .req(arb_req),
    .ptr(ptr),
    .gnt(gnt),
    .idx(c)
  );
  // Write stage trails the issue stage by one ROM latency; a gap between the counters means a word is in flight
  assign issue = (state == INIT) && (iss_cnt < CW'(INIT_WORDS));
  assign wr_act = (state == INIT) && (iss_cnt != wr_cnt);
  assign clr = (state != INIT) || init_req;
  assign any = |gnt;
  assign state_nxt = init_req ? INIT : (wr_act && wr_cnt == LAST) ? RUN : state;
  assign init_done = (state == RUN);
  assign rom_addr = iss_cnt[ADDR_W-1:0];
  assign rdata = ram_q;
  assign ram_addr = wr_act ? wr_cnt[ADDR_W-1:0] : any ? addr[int'(c)*ADDR_W +: ADDR_W] : addr_q;
  assign ram_data = wr_act ? rom_q : wdata[int'(c)*DATA_W +: DATA_W];
  assign ram_wren = wr_act | (any & we[c]);
  assign ram_rden = any & ~we[c];
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= INIT_ON_RESET ? INIT : IDLE;
      iss_cnt <= '0;
      wr_cnt <= '0;
      ptr <= IW'(NUM_CH - 1);
      addr_q <= '0;
      rvalid <= '0;
    end else begin
      state <= state_nxt;
      iss_cnt <= clr ? '0 : iss_cnt + CW'(issue);
      wr_cnt <= clr ? '0 : wr_cnt + CW'(wr_act);
      if (any) ptr <= c;
      addr_q <= ram_addr;
      rvalid <= gnt & ~we;
    end
  end
endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// tb_slc3_mem_arbiter: scoreboard bench with ROM/RAM models, three channels, four-word init image
module tb_slc3_mem_arbiter;
  localparam int DW = 16, AW = 10, NC = 3, IWORDS = 4;
  logic Clk = 1'b0, Reset_n = 1'b0, init_req = 1'b0;
  logic [AW-1:0] rom_addr, ram_addr;
  logic [DW-1:0] rom_q, rdata, ram_data, ram_q;
  logic [NC-1:0] req = '0, we = '0, gnt, rvalid, last_gnt;
  logic [NC*AW-1:0] addr = '0;
  logic [NC*DW-1:0] wdata = '0;
  logic ram_wren, ram_rden, init_done;
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];
  typedef struct {int ch; logic [DW-1:0] data;} rd_t;
  rd_t sb[$];
  int n_chk = 0, n_pass = 0, m_ptr = NC - 1;

  slc3_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .INIT_WORDS(IWORDS), .INIT_ON_RESET(1'b1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .init_req(init_req), .init_done(init_done),
    .rom_addr(rom_addr), .rom_q(rom_q), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_q(ram_q)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    rom_q <= 16'hA000 + 16'(rom_addr);
    if (ram_wren) mem[ram_addr] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic set_ch(input int c, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[c] = r;
    we[c] = w;
    addr[c*AW +: AW] = a;
    wdata[c*DW +: DW] = d;
  endtask

  // One clock: compare outputs at the falling edge, update the models, return just after the rising edge
  task automatic cyc(input bit run, input int rk);
    rd_t e;
    logic [NC-1:0] eg, erv;
    int ec;
    logic [AW-1:0] a;
    @(negedge Clk);
    erv = '0;
    e.ch = 0;
    e.data = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      erv[e.ch] = 1'b1;
    end
    check("rvalid", 32'(rvalid), 32'(erv));
    if (erv != 0) check("rdata", 32'(rdata), 32'(e.data));
    check("init_done", 32'(init_done), 32'(run));
    if (rk >= 0 && rk < IWORDS) check("rom_addr", 32'(rom_addr), 32'(rk));
    if (rk >= 0) begin
      check("init_wren", 32'(ram_wren), 32'(rk > 0));
      if (rk > 0) begin
        check("init_waddr", 32'(ram_addr), 32'(rk - 1));
        check("init_wdata", 32'(ram_data), 32'(16'hA000 + rk - 1));
      end
    end
    eg = '0;
    ec = 0;
    if (run) for (int i = 1; i <= NC; i++) if (req[(m_ptr + i) % NC]) begin
      ec = (m_ptr + i) % NC;
      eg[ec] = 1'b1;
      break;
    end
    last_gnt = gnt;
    check("gnt", 32'(gnt), 32'(eg));
    if (eg != 0) begin
      m_ptr = ec;
      a = addr[ec*AW +: AW];
      if (we[ec]) ref_mem[a] = wdata[ec*DW +: DW];
      else begin
        e.ch = ec;
        e.data = ref_mem[a];
        sb.push_back(e);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic do_init();
    for (int k = 0; k <= IWORDS; k++) cyc(1'b0, k);
    for (int i = 0; i < IWORDS; i++) ref_mem[i] = 16'hA000 + 16'(i);
  endtask

  initial begin
    set_ch(0, 1'b1, 1'b0, 10'd0, 16'd0);
    set_ch(1, 1'b1, 1'b0, 10'd1, 16'd0);
    repeat (2) @(posedge Clk);
    #1;
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    Reset_n = 1'b1;
    do_init();
    for (int i = 0; i < IWORDS; i++) check("ram_image", 32'(mem[i]), 32'(16'hA000 + i));
    for (int i = 0; i < 6; i++) begin
      set_ch(0, 1'b1, 1'b0, AW'(i % 4), 16'd0);
      set_ch(1, 1'b1, 1'b0, AW'((i + 2) % 4), 16'd0);
      cyc(1'b1, -1);
      check("alt_gnt", 32'(last_gnt), (i % 2 == 1) ? 32'd2 : 32'd1);
    end
    req = '0;
    cyc(1'b1, -1);
    set_ch(0, 1'b1, 1'b1, 10'h010, 16'h1234);
    cyc(1'b1, -1);
    check("wr_gnt", 32'(last_gnt), 32'd1);
    set_ch(0, 1'b1, 1'b0, 10'h010, 16'h0);
    cyc(1'b1, -1);
    check("rd_gnt", 32'(last_gnt), 32'd1);
    req = '0;
    cyc(1'b1, -1);
    set_ch(2, 1'b1, 1'b0, 10'd1, 16'd0);
    cyc(1'b1, -1);
    check("ch2_first", 32'(last_gnt), 32'd4);
    set_ch(0, 1'b1, 1'b0, 10'd2, 16'd0);
    set_ch(1, 1'b1, 1'b0, 10'h010, 16'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, -1);
      check("rr3_gnt", 32'(last_gnt), 32'(1 << (i % 3)));
    end
    req = '0;
    cyc(1'b1, -1);
    set_ch(1, 1'b1, 1'b0, 10'd2, 16'd0);
    init_req = 1'b1;
    cyc(1'b1, -1);
    init_req = 1'b0;
    check("ireq_gnt", 32'(last_gnt), 32'd2);
    do_init();
    cyc(1'b1, -1);
    check("post_init_gnt", 32'(last_gnt), 32'd2);
    req = '0;
    cyc(1'b1, -1);
    set_ch(0, 1'b1, 1'b0, 10'd3, 16'd0);
    cyc(1'b1, -1);
    req = '0;
    check("pre_rst_rvalid", 32'(rvalid), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("rd_rst_rvalid", 32'(rvalid), 32'd0);
    check("rd_rst_init_done", 32'(init_done), 32'd0);
    sb.delete();
    m_ptr = NC - 1;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    cyc(1'b0, 0);
    cyc(1'b0, 1);
    check("mid_init_rom_addr", 32'(rom_addr), 32'd2);
    Reset_n = 1'b0;
    #1;
    check("init_rst_rom_addr", 32'(rom_addr), 32'd0);
    check("init_rst_init_done", 32'(init_done), 32'd0);
    check("init_rst_rvalid", 32'(rvalid), 32'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    do_init();
    set_ch(2, 1'b1, 1'b0, 10'd1, 16'd0);
    cyc(1'b1, -1);
    check("final_gnt", 32'(last_gnt), 32'd4);
    req = '0;
    cyc(1'b1, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
